sprite_update_scheduler: RTL
============================

# sprite_update_scheduler

Owns the on-screen square/sprite table (position and colour per entry) used by the VGA renderer. Two update requesters, player logic (port 0) and obstacle logic (port 1), share the single table write port. Writes are admitted only inside the vertical-blanking window, so a frame is never drawn from a half-updated table. Arbitration between the requesters is round-robin, with a per-frame write budget. The renderer reads the table through a registered read port.

## Interface
- NUM_SPRITES, 20, number of table entries
- IDX_W, 5, entry index width
- COORD_W, 10, x/y coordinate width
- COLOR_W, 9, colour width ({R[2:0],G[2:0],B[2:0]})
- MAX_WRITES, 16, writes accepted per blanking window
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- vblank  in  1  level, high while v_count >= 480 (from timing generator)
- req0_valid, req1_valid  in  1  update request
- req0_idx, req1_idx  in  IDX_W  target entry
- req0_x, req1_x / req0_y, req1_y  in  COORD_W  new top-left position
- req0_color, req1_color  in  COLOR_W  new colour
- req0_ready, req1_ready  out  1  transfer accepted when valid && ready
- rd_idx  in  IDX_W  renderer read address
- rd_x, rd_y  out  COORD_W  registered entry position
- rd_color  out  COLOR_W  registered entry colour
- commit_done  out  1  one-cycle pulse when a write window closes
- frame_count  out  16  completed windows, wraps 0xFFFF->0
- err_idx  out  1  sticky, out-of-range index was accepted

## Operation
- States:
  - ACTIVE: both ready=0.
  - OPEN: writes are admitted.
- ACTIVE->OPEN on the vblank rising edge (vblank=1 && vblank_d=0).
  - write_cnt <= 0 on this transition.
- OPEN->ACTIVE when vblank=0, or when an accepted transfer makes write_cnt == MAX_WRITES.
  - On this transition: commit_done=1 for one cycle, frame_count += 1.
- Ready rules (combinational from state, vblank, valids, rr_ptr):
  - Ready is only asserted when state==OPEN && vblank==1 && write_cnt < MAX_WRITES.
  - Only one valid: that requester gets ready.
  - Both valid: requester rr_ptr gets ready, the other gets 0.
- At most one transfer per cycle.
  - After a transfer, rr_ptr <= the non-granted port.
  - With no transfer, rr_ptr is held.
- Accepted transfer:
  - Entry idx is written {x, y, color} at the same clock edge.
  - write_cnt increments.
- Index >= NUM_SPRITES:
  - Handshake completes and counts against the budget.
  - The table is unchanged and err_idx <= 1, held until reset.
- Read port: rd_* <= table[rd_idx] every cycle, independent of state.
  - rd_idx >= NUM_SPRITES returns all zeros.
  - Read and write of the same index in the same cycle returns the old value.
- Reset values:
  - state=ACTIVE, all table entries 0, rr_ptr=0, write_cnt=0.
  - frame_count=0, err_idx=0, commit_done=0, rd_*=0, ready=0.
  - vblank_d=1, so no window opens if reset is released while vblank is already high.
- Reset mid-OPEN aborts the window: no commit_done pulse, frame_count stays 0.

## Timing
- Ready may depend combinationally on valid; valid must not depend on ready.
- Write-to-table latency is 1 edge. A write accepted at edge n is visible on rd_* after edge n+1 when rd_idx matches.
- Window opens the cycle after vblank first samples high: ready can first be 1 one cycle after the vblank rise.
- vblank falling:
  - Ready drops in the same cycle vblank is sampled 0, so no transfer is accepted that cycle.
  - commit_done pulses on the next cycle.
- Budget exhaustion: the MAX_WRITES-th transfer completes, ready=0 from the next cycle, and commit_done pulses that next cycle.
- A requester holding valid during ACTIVE waits with its payload stable; nothing is lost.
- Throughput: 1 write/cycle, max MAX_WRITES per frame (45 vblank lines × 800 clocks always exceeds the budget).

## Test plan
- Reset, then raise vblank. req0 writes idx=3 x=200 y=50 color=9'h1C0. rd_idx=3 two cycles later -> rd_x=200, rd_y=50, rd_color=9'h1C0; after vblank falls, commit_done=1 once and frame_count=1.
- Both ports valid continuously for 6 cycles in OPEN -> grants alternate 0,1,0,1,0,1 (rr_ptr starts 0); each port gets 3 writes.
- req1 valid with vblank=0 -> req1_ready=0 for 100 cycles. Raise vblank: req1_ready=1 on cycle 2 and the write lands.
- MAX_WRITES=16, req0 always valid through a long vblank -> exactly 16 transfers, ready=0 afterwards, commit_done pulses the cycle after the 16th write.
- req0 writes idx=25 -> handshake completes, err_idx=1, rd_idx=0..19 unchanged; err_idx stays 1 across windows until reset.
- Reset asserted mid-OPEN after 2 writes -> all rd_* read 0, no commit_done pulse, frame_count=0. Release reset with vblank high -> no window until the next vblank rise.

Source files
------------

// File: rtl/sprite_update_scheduler.sv
// Sprite table shared by player (port 0) and obstacle (port 1) logic: writes are admitted only in a
// vertical-blanking window, round-robin arbitrated and capped per frame; the renderer reads through a registered port.
module sprite_update_scheduler #(
  parameter int NUM_SPRITES = 20,
  parameter int IDX_W       = 5,
  parameter int COORD_W     = 10,
  parameter int COLOR_W     = 9,
  parameter int MAX_WRITES  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vblank,
  input  logic               req0_valid,
  input  logic [IDX_W-1:0]   req0_idx,
  input  logic [COORD_W-1:0] req0_x,
  input  logic [COORD_W-1:0] req0_y,
  input  logic [COLOR_W-1:0] req0_color,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [IDX_W-1:0]   req1_idx,
  input  logic [COORD_W-1:0] req1_x,
  input  logic [COORD_W-1:0] req1_y,
  input  logic [COLOR_W-1:0] req1_color,
  output logic               req1_ready,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  output logic [COLOR_W-1:0] rd_color,
  output logic               commit_done,
  output logic [15:0]        frame_count,
  output logic               err_idx
);

  localparam int ENTRY_W = 2 * COORD_W + COLOR_W;
  localparam int CNT_W   = $clog2(MAX_WRITES + 1);
  localparam logic [CNT_W-1:0] BUDGET     = CNT_W'(MAX_WRITES);
  localparam logic [CNT_W-1:0] LAST_WRITE = CNT_W'(MAX_WRITES - 1);
  localparam logic [IDX_W:0]   TABLE_SIZE = (IDX_W + 1)'(NUM_SPRITES);

  typedef enum logic [0:0] {
    ST_ACTIVE = 1'b0,
    ST_OPEN   = 1'b1
  } state_t;

  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return ({1'b0, idx} < TABLE_SIZE);
  endfunction

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y,
                                                    input logic [COLOR_W-1:0] color);
    return {x, y, color};
  endfunction

  state_t               state_r;
  state_t               state_nxt_s;
  logic                 vblank_d_r;
  logic                 rr_ptr_r;
  logic [CNT_W-1:0]     write_cnt_r;
  logic [ENTRY_W-1:0]   table_r [NUM_SPRITES];
  logic                 grant0_s;
  logic                 grant1_s;
  logic                 xfer_s;
  logic                 open_evt_s;
  logic                 close_s;
  logic [IDX_W-1:0]     wr_idx_s;
  logic [ENTRY_W-1:0]   wr_data_s;
  logic [ENTRY_W-1:0]   rd_data_s;
  logic [ENTRY_W-1:0]   rd_data_r;
  logic                 commit_done_r;
  logic [15:0]          frame_count_r;
  logic                 err_idx_r;

  // Arbitration: one grant per cycle, only inside an open window with budget left.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (!reset && state_r == ST_OPEN && vblank && write_cnt_r < BUDGET) begin
      if (req0_valid && req1_valid) begin
        grant0_s = ~rr_ptr_r;
        grant1_s = rr_ptr_r;
      end else begin
        grant0_s = req0_valid;
        grant1_s = req1_valid;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign xfer_s     = grant0_s | grant1_s;
  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;

  // Write payload mux follows the granted port.
  always_comb begin
    wr_idx_s  = req0_idx;
    wr_data_s = pack_entry(req0_x, req0_y, req0_color);
    if (grant1_s) begin
      wr_idx_s  = req1_idx;
      wr_data_s = pack_entry(req1_x, req1_y, req1_color);
    end else begin
      wr_idx_s  = req0_idx;
      wr_data_s = pack_entry(req0_x, req0_y, req0_color);
    end
  end

  // Window FSM next state; closing on the last budgeted write or on vblank falling.
  always_comb begin
    state_nxt_s = state_r;
    open_evt_s  = 1'b0;
    close_s     = 1'b0;
    case (state_r)
      ST_ACTIVE: begin
        if (vblank && !vblank_d_r) begin
          state_nxt_s = ST_OPEN;
          open_evt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      ST_OPEN: begin
        if (!vblank) begin
          state_nxt_s = ST_ACTIVE;
          close_s     = 1'b1;
        end else if (xfer_s && write_cnt_r == LAST_WRITE) begin
          state_nxt_s = ST_ACTIVE;
          close_s     = 1'b1;
        end else begin
          state_nxt_s = ST_OPEN;
        end
      end
      default: begin
        state_nxt_s = ST_ACTIVE;
      end
    endcase
  end

  // Window FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_ACTIVE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Window bookkeeping; vblank_d resets high so a window needs a genuine vblank rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      vblank_d_r    <= 1'b1;
      write_cnt_r   <= '0;
      rr_ptr_r      <= 1'b0;
      commit_done_r <= 1'b0;
      frame_count_r <= 16'd0;
      err_idx_r     <= 1'b0;
    end else begin
      vblank_d_r    <= vblank;
      commit_done_r <= close_s;
      if (open_evt_s) begin
        write_cnt_r <= '0;
      end else if (xfer_s) begin
        write_cnt_r <= write_cnt_r + CNT_W'(1);
      end else begin
        write_cnt_r <= write_cnt_r;
      end
      if (xfer_s) begin
        rr_ptr_r <= grant0_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
      if (close_s) begin
        frame_count_r <= frame_count_r + 16'd1;
      end else begin
        frame_count_r <= frame_count_r;
      end
      if (xfer_s && !idx_in_range(wr_idx_s)) begin
        err_idx_r <= 1'b1;
      end else begin
        err_idx_r <= err_idx_r;
      end
    end
  end

  // Sprite table; accepted out-of-range indices consume budget but leave the table untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        table_r[i] <= '0;
      end
    end else if (xfer_s && idx_in_range(wr_idx_s)) begin
      table_r[wr_idx_s] <= wr_data_s;
    end else begin
      table_r <= table_r;
    end
  end

  // Read lookup; out-of-range addresses return zero.
  always_comb begin
    rd_data_s = '0;
    if (idx_in_range(rd_idx)) begin
      rd_data_s = table_r[rd_idx];
    end else begin
      rd_data_s = '0;
    end
  end

  // Registered read port; sees the pre-write value on a same-cycle collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_r <= '0;
    end else begin
      rd_data_r <= rd_data_s;
    end
  end

  assign {rd_x, rd_y, rd_color} = rd_data_r;
  assign commit_done            = commit_done_r;
  assign frame_count            = frame_count_r;
  assign err_idx                = err_idx_r;

endmodule
